// File: rtl/mips_irq_timer_pkg.sv
// Shared definitions for the MIPS54 SoC interrupt/timer block: register map
// and the position of the timer bit in the pending vector.
package mips_soc_pkg;

  typedef enum logic [1:0] {
    ADDR_COUNT   = 2'd0,
    ADDR_COMPARE = 2'd1,
    ADDR_PENDING = 2'd2,
    ADDR_MASK    = 2'd3
  } reg_addr_e;

  // The timer sits directly above the external lines.
  function automatic int timer_bit(input int n_irq);
    return n_irq;
  endfunction

endpackage

// File: rtl/mips_irq_timer_if.sv
// CPU register port of the interrupt/timer unit, decoded in the SoC top.
interface mips_irq_timer_if;

  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/mips_irq_timer_sync.sv
// Per-line synchroniser: SYNC_STAGES flops, then either the level itself or a
// one-cycle rising-edge pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  output logic o_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  if (LEVEL) begin : g_level
    assign o_evt = w_sync_out;
  end else begin : g_edge
    logic r_dly;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_dly <= 1'b0;
      end else begin
        r_dly <= w_sync_out;
      end
    end

    assign o_evt = w_sync_out & ~r_dly;
  end

endmodule

// File: rtl/mips_irq_timer.sv
// Interrupt and Count/Compare timer unit feeding CP0: synchronised external
// lines with sticky or level pending bits, masking, and a prescaled timer.
module mips_irq_timer
  import mips_soc_pkg::*;
#(
  parameter int                 N_IRQ       = 5,
  parameter int                 COUNT_W     = 32,
  parameter int                 PRESCALE    = 2,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0]   LEVEL_MASK  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     irq_in,
  mips_irq_timer_if.slave      bus,
  input  logic                 status_ie,
  input  logic                 status_exl,
  output logic                 intr,
  output logic [N_IRQ:0]       ip,
  output logic                 timer_int
);

  localparam int TBIT  = timer_bit(N_IRQ);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   r_pre;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_compare;
  logic [N_IRQ:0]     r_mask;
  logic               r_tpend;

  logic               w_wr_count;
  logic               w_wr_compare;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_tick;
  logic               w_count_upd;
  logic [COUNT_W-1:0] w_count_next;
  logic               w_match;
  logic [N_IRQ-1:0]   w_evt;
  logic [N_IRQ-1:0]   w_lines;
  logic [N_IRQ:0]     w_pending;
  logic [N_IRQ:0]     w_active;
  logic               w_unused;

  assign w_wr_count   = bus.we && (bus.addr == ADDR_COUNT);
  assign w_wr_compare = bus.we && (bus.addr == ADDR_COMPARE);
  assign w_wr_pend    = bus.we && (bus.addr == ADDR_PENDING);
  assign w_wr_mask    = bus.we && (bus.addr == ADDR_MASK);

  // Upper write-data bits beyond each register width are deliberately ignored.
  assign w_unused = &{1'b0, bus.wdata};

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .LEVEL       (LEVEL_MASK[i])
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_irq (irq_in[i]),
      .o_evt (w_evt[i])
    );

    if (LEVEL_MASK[i]) begin : g_level
      assign w_lines[i] = w_evt[i];
    end else begin : g_edge
      logic r_pend;

      // A new edge outranks a simultaneous software clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pend <= 1'b0;
        end else if (w_evt[i]) begin
          r_pend <= 1'b1;
        end else if (w_wr_pend && bus.wdata[i]) begin
          r_pend <= 1'b0;
        end
      end

      assign w_lines[i] = r_pend;
    end
  end

  assign w_pending = {r_tpend, w_lines};
  assign w_active  = w_pending & r_mask;

  // A COUNT write restarts the prescaler and suppresses that cycle's tick.
  assign w_tick = (r_pre == PRE_MAX) && !w_wr_count;

  always_comb begin
    w_count_next = r_count;
    w_count_upd  = 1'b0;
    if (w_wr_count) begin
      w_count_next = bus.wdata[COUNT_W-1:0];
      w_count_upd  = 1'b1;
    end else if (w_tick) begin
      w_count_next = r_count + 1'b1;
      w_count_upd  = 1'b1;
    end
  end

  assign w_match = w_count_upd && (w_count_next == r_compare);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '1;
      r_mask    <= '0;
      r_tpend   <= 1'b0;
      intr      <= 1'b0;
      ip        <= '0;
      timer_int <= 1'b0;
    end else begin
      if (w_wr_count || w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_count <= w_count_next;

      if (w_wr_compare) begin
        r_compare <= bus.wdata[COUNT_W-1:0];
      end
      if (w_wr_mask) begin
        r_mask <= bus.wdata[N_IRQ:0];
      end

      // Rewriting COMPARE acknowledges the timer even against a same-cycle match.
      if (w_wr_compare) begin
        r_tpend <= 1'b0;
      end else if (w_match) begin
        r_tpend <= 1'b1;
      end else if (w_wr_pend && bus.wdata[TBIT]) begin
        r_tpend <= 1'b0;
      end

      ip        <= w_active;
      timer_int <= r_tpend;
      intr      <= (|w_active) && status_ie && !status_exl;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_COUNT:   bus.rdata = 32'(r_count);
      ADDR_COMPARE: bus.rdata = 32'(r_compare);
      ADDR_PENDING: bus.rdata = 32'(w_pending);
      ADDR_MASK:    bus.rdata = 32'(r_mask);
      default:      bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_irq_timer.sv
// Directed bench for mips_irq_timer: expected values queued on stimulus and
// popped against DUT outputs.
module tb_mips_irq_timer;

  localparam int N_IRQ = 5;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IRQ-1:0] irqIn;
  logic             statusIe;
  logic             statusExl;
  logic             intr;
  logic [N_IRQ:0]   ip;
  logic             timerInt;

  int   errors = 0;
  int   checks = 0;
  exp_t expQ[$];

  mips_irq_timer_if bus ();

  mips_irq_timer #(
    .N_IRQ       (N_IRQ),
    .COUNT_W     (32),
    .PRESCALE    (2),
    .SYNC_STAGES (2),
    .LEVEL_MASK  (5'b00001)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irqIn),
    .bus        (bus),
    .status_ie  (statusIe),
    .status_exl (statusExl),
    .intr       (intr),
    .ip         (ip),
    .timer_int  (timerInt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=%h", observed);
    end else begin
      e = expQ.pop_front();
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step(1);
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic checkRead(input string tag, input logic [1:0] a, input logic [31:0] value);
    applyStimulus(tag, value);
    bus.addr = a;
    #1;
    checkOutput(bus.rdata);
  endtask

  task automatic checkSig(input string tag, input logic [31:0] observed, input logic [31:0] value);
    applyStimulus(tag, value);
    checkOutput(observed);
  endtask

  initial begin
    reset     = 1'b1;
    irqIn     = '0;
    statusIe  = 1'b0;
    statusExl = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    step(2);
    reset = 1'b0;

    checkRead("rst_count", 2'd0, 32'h0);
    checkRead("rst_compare", 2'd1, 32'hFFFF_FFFF);
    checkRead("rst_pending", 2'd2, 32'h0);
    checkRead("rst_mask", 2'd3, 32'h0);
    checkSig("rst_intr", intr, 32'h0);
    checkSig("rst_ip", ip, 32'h0);

    // Edge line 2: one-cycle pulse, intr four clocks later
    busWrite(2'd3, 32'h3F);
    statusIe = 1'b1;
    irqIn    = 5'b00100;
    step(1);
    irqIn = '0;
    step(2);
    checkSig("edge_intr_early", intr, 32'h0);
    step(1);
    checkSig("edge_intr", intr, 32'h1);
    checkRead("edge_pending", 2'd2, 32'h04);
    checkSig("edge_ip", ip, 32'h04);
    busWrite(2'd2, 32'h04);
    checkSig("w1c_intr_lag", intr, 32'h1);
    step(1);
    checkSig("w1c_intr", intr, 32'h0);
    checkRead("w1c_pending", 2'd2, 32'h0);

    // Timer match via prescaled ticks
    busWrite(2'd1, 32'd10);
    busWrite(2'd0, 32'd8);
    step(3);
    checkRead("tmr_pend_early", 2'd2, 32'h0);
    step(1);
    checkRead("tmr_pend", 2'd2, 32'h20);
    checkSig("tmr_int_lag", timerInt, 32'h0);
    step(1);
    checkSig("tmr_int", timerInt, 32'h1);
    checkSig("tmr_intr", intr, 32'h1);
    busWrite(2'd1, 32'd50);
    checkRead("cmp_clear_pend", 2'd2, 32'h0);
    step(1);
    checkSig("cmp_clear_int", timerInt, 32'h0);

    // COMPARE write on the matching tick: clear wins
    busWrite(2'd1, 32'd22);
    busWrite(2'd0, 32'd20);
    step(3);
    busWrite(2'd1, 32'd5);
    checkRead("race_count", 2'd0, 32'd22);
    checkRead("race_pend", 2'd2, 32'h0);
    step(2);
    checkSig("race_int", timerInt, 32'h0);

    // Count wraps to 0 and matches COMPARE=0; W1C clears the timer bit
    busWrite(2'd1, 32'd0);
    busWrite(2'd0, 32'hFFFF_FFFF);
    step(2);
    checkRead("wrap_count", 2'd0, 32'h0);
    checkRead("wrap_pend", 2'd2, 32'h20);
    busWrite(2'd2, 32'h20);
    checkRead("wrap_w1c", 2'd2, 32'h0);

    // Level line 0 ignores W1C and follows the synchronised input
    irqIn = 5'b00001;
    step(2);
    checkRead("lvl_pend", 2'd2, 32'h01);
    busWrite(2'd2, 32'h01);
    checkRead("lvl_w1c", 2'd2, 32'h01);
    checkSig("lvl_intr", intr, 32'h1);
    irqIn = '0;
    step(1);
    checkRead("lvl_drop_early", 2'd2, 32'h01);
    step(1);
    checkRead("lvl_drop", 2'd2, 32'h00);

    // EXL blocks intr while ip shows the pending line
    statusExl = 1'b1;
    irqIn     = 5'b01000;
    step(1);
    irqIn = '0;
    step(3);
    checkSig("exl_ip", ip, 32'h08);
    checkSig("exl_intr", intr, 32'h0);
    statusExl = 1'b0;
    step(1);
    checkSig("exl_drop_intr", intr, 32'h1);

    // Reset while an interrupt is pending
    reset = 1'b1;
    step(1);
    checkSig("mid_rst_intr", intr, 32'h0);
    checkSig("mid_rst_ip", ip, 32'h0);
    checkSig("mid_rst_tint", timerInt, 32'h0);
    checkRead("mid_rst_count", 2'd0, 32'h0);
    checkRead("mid_rst_compare", 2'd1, 32'hFFFF_FFFF);
    checkRead("mid_rst_pending", 2'd2, 32'h0);
    checkRead("mid_rst_mask", 2'd3, 32'h0);
    reset = 1'b0;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
